// File: rtl/i2c_cmd_seq_if.sv
`default_nettype none
// =============================================================================
// Module : i2c_cmd_seq_if
// Host command / FIFO / i2c_top-side signal bundle for i2c_cmd_seq.
// Rev    : 1.0
// =============================================================================
interface i2c_cmd_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic       cmd_rw;
    logic [3:0] cmd_nbyte;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tx_full;
    logic       rx_rd;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       m_en;
    logic [6:0] m_address;
    logic       m_rw;
    logic [3:0] m_N_byte;
    logic [7:0] m_data_in;
    logic [7:0] m_data_out;
    logic       m_byte_done;
    logic       m_busy;
    logic       done;
    logic       tx_ovf;
    logic       rx_ovf;
    logic       err_timeout;

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_addr, cmd_rw, cmd_nbyte, tx_wr, tx_data, rx_rd,
               m_data_out, m_byte_done, m_busy,
        output cmd_ready, tx_full, rx_data, rx_empty, m_en, m_address, m_rw,
               m_N_byte, m_data_in, done, tx_ovf, rx_ovf, err_timeout
    );

    // Host / master-model side
    modport master (
        output cmd_valid, cmd_addr, cmd_rw, cmd_nbyte, tx_wr, tx_data, rx_rd,
               m_data_out, m_byte_done, m_busy,
        input  cmd_ready, tx_full, rx_data, rx_empty, m_en, m_address, m_rw,
               m_N_byte, m_data_in, done, tx_ovf, rx_ovf, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/i2c_cmd_seq.sv
`default_nettype none
// =============================================================================
// Module : i2c_cmd_seq
// Command sequencer in front of i2c_top with TX/RX byte FIFOs.
// Optional watchdog enabled by macro I2C_TIMEOUT_EN.
// Rev    : 1.0
// =============================================================================
module i2c_cmd_seq #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic     clk,
    input  wire logic     reset,
    i2c_cmd_seq_if.slave  bus
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_XFER      = 2'd2,
        S_WAIT_IDLE = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [6:0]      r_addr;
    logic            r_rw;
    logic [3:0]      r_nbyte, r_cnt;
    logic            r_done, w_done_nxt, w_m_en;
    logic            r_tx_ovf, r_rx_ovf;

    logic [7:0]      r_tx_mem [DEPTH];
    logic [c_PW-1:0] r_tx_wp, r_tx_rp;
    logic [c_CW-1:0] r_tx_cnt;
    logic [7:0]      r_rx_mem [DEPTH];
    logic [c_PW-1:0] r_rx_wp, r_rx_rp;
    logic [c_CW-1:0] r_rx_cnt;

    logic            w_accept, w_byte, w_last, w_timeout;
    logic            w_tx_full, w_rx_full, w_rx_empty;
    logic            w_tx_pop, w_tx_push, w_rx_pop, w_rx_push;
    logic [c_CW-1:0] w_tx_pop_n;

    assign w_tx_full  = (r_tx_cnt == c_FULL);
    assign w_rx_full  = (r_rx_cnt == c_FULL);
    assign w_rx_empty = (r_rx_cnt == '0);

    // A write is only accepted once every one of its bytes is already queued
    assign bus.cmd_ready = (r_state == S_IDLE) && !r_done &&
                           (bus.cmd_rw || (5'(r_tx_cnt) >= {1'b0, bus.cmd_nbyte}));
    assign w_accept  = bus.cmd_valid && bus.cmd_ready;
    assign w_byte    = (r_state == S_XFER) && bus.m_byte_done;
    assign w_last    = w_byte && ((r_cnt + 4'd1) == r_nbyte);

    assign w_tx_pop  = w_byte && !r_rw && (r_tx_cnt != '0);
    assign w_tx_push = bus.tx_wr && (!w_tx_full || w_tx_pop);
    assign w_rx_pop  = bus.rx_rd && !w_rx_empty;
    assign w_rx_push = w_byte && r_rw && (!w_rx_full || w_rx_pop);

`ifdef I2C_TIMEOUT_EN
    localparam int c_WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_WDW-1:0] r_wdog;
    logic             r_err_timeout;
    logic [4:0]       w_rem;

    assign w_timeout = (r_state != S_IDLE) && !bus.m_byte_done &&
                       (r_wdog == c_WDW'(TIMEOUT_CYCLES));
    // Bytes of the aborted write still sitting in the TX FIFO
    assign w_rem = {1'b0, r_nbyte} - {1'b0, r_cnt};
    assign w_tx_pop_n = w_tx_pop ? c_CW'(1) :
                        (w_timeout && !r_rw) ?
                            ((5'(r_tx_cnt) < w_rem) ? r_tx_cnt : c_CW'(w_rem)) : '0;
    assign bus.err_timeout = r_err_timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog        <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_accept || bus.m_byte_done || (r_state == S_IDLE))
                r_wdog <= '0;
            else if (r_wdog != c_WDW'(TIMEOUT_CYCLES))
                r_wdog <= r_wdog + 1'b1;
            if (w_timeout)
                r_err_timeout <= 1'b1;
        end
    end
`else
    assign w_timeout  = 1'b0;
    assign w_tx_pop_n = w_tx_pop ? c_CW'(1) : '0;
    // Watchdog absent: flag is a constant 0
    assign bus.err_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_m_en      = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_nxt = S_START;
            end
            S_START: begin
                w_m_en = 1'b1;
                if (bus.m_busy)
                    w_state_nxt = (r_nbyte == 4'd0) ? S_WAIT_IDLE : S_XFER;
            end
            S_XFER: begin
                w_m_en = !w_last;
                if (w_last)
                    w_state_nxt = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (!bus.m_busy) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_m_en      = 1'b0;
            w_done_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_done   <= 1'b0;
            r_addr   <= '0;
            r_rw     <= 1'b0;
            r_nbyte  <= '0;
            r_cnt    <= '0;
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_accept) begin
                r_addr  <= bus.cmd_addr;
                r_rw    <= bus.cmd_rw;
                r_nbyte <= bus.cmd_nbyte;
                r_cnt   <= '0;
            end else if (w_byte) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (bus.tx_wr && !w_tx_push)
                r_tx_ovf <= 1'b1;
            if (w_byte && r_rw && !w_rx_push)
                r_rx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tx_mem[i] <= '0;
                r_rx_mem[i] <= '0;
            end
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_mem[r_tx_wp] <= bus.tx_data;
                r_tx_wp           <= r_tx_wp + 1'b1;
            end
            r_tx_rp  <= r_tx_rp + c_PW'(w_tx_pop_n);
            r_tx_cnt <= r_tx_cnt + c_CW'(w_tx_push) - w_tx_pop_n;

            if (w_rx_push) begin
                r_rx_mem[r_rx_wp] <= bus.m_data_out;
                r_rx_wp           <= r_rx_wp + 1'b1;
            end
            if (w_rx_pop)
                r_rx_rp <= r_rx_rp + 1'b1;
            r_rx_cnt <= r_rx_cnt + c_CW'(w_rx_push) - c_CW'(w_rx_pop);
        end
    end

    assign bus.m_en      = w_m_en;
    assign bus.m_address = r_addr;
    assign bus.m_rw      = r_rw;
    assign bus.m_N_byte  = r_nbyte;
    assign bus.m_data_in = r_tx_mem[r_tx_rp];
    assign bus.tx_full   = w_tx_full;
    assign bus.rx_data   = r_rx_mem[r_rx_rp];
    assign bus.rx_empty  = w_rx_empty;
    assign bus.done      = r_done;
    assign bus.tx_ovf    = r_tx_ovf;
    assign bus.rx_ovf    = r_rx_ovf;

endmodule
`default_nettype wire
